// File: rtl/acq_pkg.sv
// -----------------------------------------------------------------------------
// acq_pkg
// Shared types and constants for the sensor acquisition front end.
//  - acq_state_e      : frame sequencer FSM states
//  - NUM_CHANNELS_DEF : default channel count covered by the channel mask
//  - MASK_ALL_ON      : reset value of the active / pending channel mask
//  - mask_all_on()    : all-ones mask of an arbitrary width
// -----------------------------------------------------------------------------
package acq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        CONVERT   = 3'd2,
        SETTLE    = 3'd3,
        PUBLISH   = 3'd4,
        HOLD      = 3'd5
    } acq_state_e;

    localparam int NUM_CHANNELS_DEF = 16;

    localparam logic [NUM_CHANNELS_DEF-1:0] MASK_ALL_ON = {NUM_CHANNELS_DEF{1'b1}};

    // All-ones mask sized for the widest supported channel count; callers
    // truncate to their own width.
    function automatic logic [63:0] mask_all_on();
        return {64{1'b1}};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic single-bit two-flop synchroniser into the destination clock domain.
// Ports:
//  clk      in  destination clock
//  rst_n    in  asynchronous, active-low reset (output resets to 0)
//  d_async  in  signal from a foreign clock domain
//  q_sync   out synchronised level, two destination-clock cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic q_sync
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture; the first stage may go metastable and is never used directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d_async;
            sync_r <= meta_r;
        end
    end

    assign q_sync = sync_r;

endmodule

// File: rtl/acq_frame_sequencer.sv
// -----------------------------------------------------------------------------
// acq_frame_sequencer
// Frame-level scheduler for the sensor acquisition front end (sensor_clk domain).
// Issues a periodic AFE conversion request, waits for the AFE handshake, lets
// the analog path settle, then publishes the frame to the channel aggregator
// with a VALID_HOLD-wide strobe, holding publication while the aggregator's
// sweep is running. Channel-mask updates are staged and applied on publish.
// Ports:
//  sensor_clk, rst_n   clock, asynchronous active-low reset
//  enable              run/stop; dropping it returns the FSM to IDLE
//  cfg_period          frame period in cycles (0 and 1 both mean every cycle)
//  cfg_settle          cycles from conversion done to publish decision (0 = none)
//  cfg_mask_in/_wr     pending channel-mask write
//  afe_conv_done       AFE conversion complete, sampled in CONVERT
//  sweep_busy_async    aggregator sweep active (foreign clock domain)
//  err_clr             clears the sticky error flags
//  afe_conv_start      one-cycle conversion request
//  sensor_valid_all    publish strobe, VALID_HOLD cycles wide
//  channel_mask        active mask, changes only with a publish
//  frame_count         published frames, wrapping
//  overrun_err         sticky: a tick was dropped because a frame was in flight
//  timeout_err         sticky: the AFE never answered a conversion request
//  busy                a frame is in flight
// -----------------------------------------------------------------------------
module acq_frame_sequencer
    import acq_pkg::*;
#(
    parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int PERIOD_WIDTH = 16,
    parameter int SETTLE_WIDTH = 8,
    parameter int CONV_TIMEOUT = 1024,
    parameter int VALID_HOLD   = 2,
    parameter int FCNT_WIDTH   = 16
) (
    input  logic                    sensor_clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] cfg_period,
    input  logic [SETTLE_WIDTH-1:0] cfg_settle,
    input  logic [NUM_CHANNELS-1:0] cfg_mask_in,
    input  logic                    cfg_mask_wr,
    input  logic                    afe_conv_done,
    input  logic                    sweep_busy_async,
    input  logic                    err_clr,
    output logic                    afe_conv_start,
    output logic                    sensor_valid_all,
    output logic [NUM_CHANNELS-1:0] channel_mask,
    output logic [FCNT_WIDTH-1:0]   frame_count,
    output logic                    overrun_err,
    output logic                    timeout_err,
    output logic                    busy
);

    localparam int TO_W   = $clog2(CONV_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(VALID_HOLD + 1);

    localparam logic [NUM_CHANNELS-1:0] MASK_RST    = NUM_CHANNELS'(mask_all_on());
    localparam logic [TO_W-1:0]         TO_LAST     = TO_W'(CONV_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0]       HOLD_LAST   = HOLD_W'(VALID_HOLD - 1);

    acq_state_e              state_r;
    logic                    conv_start_r;
    logic                    valid_r;
    logic                    busy_r;
    logic [TO_W-1:0]         to_cnt_r;
    logic [SETTLE_WIDTH-1:0] settle_cnt_r;
    logic [SETTLE_WIDTH-1:0] settle_len_r;
    logic [HOLD_W-1:0]       hold_cnt_r;

    logic [PERIOD_WIDTH-1:0] period_r;
    logic [PERIOD_WIDTH-1:0] per_cnt_r;
    logic [PERIOD_WIDTH-1:0] period_eff_s;
    logic                    run_s;
    logic                    tick_s;

    logic [NUM_CHANNELS-1:0] mask_r;
    logic [NUM_CHANNELS-1:0] pend_mask_r;
    logic                    pend_flag_r;
    logic [FCNT_WIDTH-1:0]   fcount_r;
    logic                    overrun_r;
    logic                    timeout_r;

    logic                    busy_s;
    logic                    publish_req_s;
    logic                    publish_go_s;
    logic                    timeout_s;

    sync_2ff u_sweep_sync (
        .clk     (sensor_clk),
        .rst_n   (rst_n),
        .d_async (sweep_busy_async),
        .q_sync  (busy_s)
    );

    // Tick detection; a period of 0 behaves like 1 (tick every cycle)
    always_comb begin
        run_s        = enable && (state_r != IDLE);
        period_eff_s = period_r;
        if (period_r == {PERIOD_WIDTH{1'b0}}) begin
            period_eff_s = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            period_eff_s = period_r;
        end
        tick_s = run_s && (per_cnt_r == (period_eff_s - {{(PERIOD_WIDTH-1){1'b0}}, 1'b1}));
    end

    // Period counter; cfg_period is re-sampled only at a wrap or while stopped
    always_ff @(posedge sensor_clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_r <= {PERIOD_WIDTH{1'b0}};
            period_r  <= {PERIOD_WIDTH{1'b0}};
        end else if (!run_s) begin
            per_cnt_r <= {PERIOD_WIDTH{1'b0}};
            period_r  <= cfg_period;
        end else if (tick_s) begin
            per_cnt_r <= {PERIOD_WIDTH{1'b0}};
            period_r  <= cfg_period;
        end else begin
            per_cnt_r <= per_cnt_r + {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Publish and timeout decisions. publish_req_s marks a cycle in which the
    // frame is ready; the strobe rises on the next cycle unless the sweep is busy.
    always_comb begin
        publish_req_s = 1'b0;
        timeout_s     = 1'b0;
        case (state_r)
            CONVERT: begin
                if (afe_conv_done) begin
                    publish_req_s = (cfg_settle == {SETTLE_WIDTH{1'b0}});
                end else begin
                    timeout_s = (to_cnt_r == TO_LAST);
                end
            end
            SETTLE: begin
                publish_req_s = (settle_cnt_r == (settle_len_r - {{(SETTLE_WIDTH-1){1'b0}}, 1'b1}));
            end
            PUBLISH: begin
                publish_req_s = 1'b1;
            end
            default: begin
                publish_req_s = 1'b0;
                timeout_s     = 1'b0;
            end
        endcase
        publish_go_s = enable && publish_req_s && !busy_s;
    end

    // Frame FSM with its per-state counters and registered request/strobe/busy
    always_ff @(posedge sensor_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            conv_start_r <= 1'b0;
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
            to_cnt_r     <= {TO_W{1'b0}};
            settle_cnt_r <= {SETTLE_WIDTH{1'b0}};
            settle_len_r <= {SETTLE_WIDTH{1'b0}};
            hold_cnt_r   <= {HOLD_W{1'b0}};
        end else if (!enable) begin
            state_r      <= IDLE;
            conv_start_r <= 1'b0;
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
            to_cnt_r     <= {TO_W{1'b0}};
            settle_cnt_r <= {SETTLE_WIDTH{1'b0}};
            hold_cnt_r   <= {HOLD_W{1'b0}};
        end else if (publish_req_s) begin
            conv_start_r <= 1'b0;
            busy_r       <= 1'b1;
            if (!busy_s) begin
                state_r    <= HOLD;
                valid_r    <= 1'b1;
                hold_cnt_r <= {HOLD_W{1'b0}};
            end else begin
                state_r <= PUBLISH;
            end
        end else begin
            conv_start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r <= WAIT_TICK;
                    busy_r  <= 1'b0;
                end
                WAIT_TICK: begin
                    if (tick_s) begin
                        state_r      <= CONVERT;
                        conv_start_r <= 1'b1;
                        busy_r       <= 1'b1;
                        to_cnt_r     <= {TO_W{1'b0}};
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                CONVERT: begin
                    // A done here always has a non-zero settle; zero settle took the publish path
                    if (afe_conv_done) begin
                        state_r      <= SETTLE;
                        settle_len_r <= cfg_settle;
                        settle_cnt_r <= {SETTLE_WIDTH{1'b0}};
                    end else if (timeout_s) begin
                        state_r <= WAIT_TICK;
                        busy_r  <= 1'b0;
                    end else begin
                        to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
                    end
                end
                SETTLE: begin
                    settle_cnt_r <= settle_cnt_r + {{(SETTLE_WIDTH-1){1'b0}}, 1'b1};
                end
                HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r <= WAIT_TICK;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Staged channel mask and frame counter. A write landing on a publish cycle
    // stays pending: the previously staged value is the one applied.
    always_ff @(posedge sensor_clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r      <= MASK_RST;
            pend_mask_r <= MASK_RST;
            pend_flag_r <= 1'b0;
            fcount_r    <= {FCNT_WIDTH{1'b0}};
        end else begin
            if (publish_go_s) begin
                fcount_r <= fcount_r + {{(FCNT_WIDTH-1){1'b0}}, 1'b1};
                if (pend_flag_r) begin
                    mask_r <= pend_mask_r;
                end else begin
                    mask_r <= mask_r;
                end
            end else begin
                fcount_r <= fcount_r;
            end
            if (cfg_mask_wr) begin
                pend_mask_r <= cfg_mask_in;
                pend_flag_r <= 1'b1;
            end else if (publish_go_s) begin
                pend_flag_r <= 1'b0;
            end else begin
                pend_flag_r <= pend_flag_r;
            end
        end
    end

    // Sticky error flags; a new error event beats a simultaneous clear
    always_ff @(posedge sensor_clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            if (tick_s && (state_r != WAIT_TICK)) begin
                overrun_r <= 1'b1;
            end else if (err_clr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
            if (enable && timeout_s) begin
                timeout_r <= 1'b1;
            end else if (err_clr) begin
                timeout_r <= 1'b0;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    assign afe_conv_start   = conv_start_r;
    assign sensor_valid_all = valid_r;
    assign channel_mask     = mask_r;
    assign frame_count      = fcount_r;
    assign overrun_err      = overrun_r;
    assign timeout_err      = timeout_r;
    assign busy             = busy_r;

endmodule

// File: tb/tb_acq_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acq_frame_sequencer
// Directed bench for acq_frame_sequencer: nominal frames, sweep back-pressure,
// overrun, conversion timeout, staged mask updates, enable drop and reset.
// -----------------------------------------------------------------------------
module tb_acq_frame_sequencer;

    logic        sensor_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] cfg_period = 16'd10;
    logic [7:0]  cfg_settle = 8'd3;
    logic [15:0] cfg_mask_in = 16'h0000;
    logic        cfg_mask_wr = 1'b0;
    logic        afe_conv_done = 1'b0;
    logic        sweep_busy_async = 1'b0;
    logic        err_clr = 1'b0;
    logic        afe_conv_start;
    logic        sensor_valid_all;
    logic [15:0] channel_mask;
    logic [15:0] frame_count;
    logic        overrun_err;
    logic        timeout_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    acq_frame_sequencer dut (
        .sensor_clk       (sensor_clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .cfg_period       (cfg_period),
        .cfg_settle       (cfg_settle),
        .cfg_mask_in      (cfg_mask_in),
        .cfg_mask_wr      (cfg_mask_wr),
        .afe_conv_done    (afe_conv_done),
        .sweep_busy_async (sweep_busy_async),
        .err_clr          (err_clr),
        .afe_conv_start   (afe_conv_start),
        .sensor_valid_all (sensor_valid_all),
        .channel_mask     (channel_mask),
        .frame_count      (frame_count),
        .overrun_err      (overrun_err),
        .timeout_err      (timeout_err),
        .busy             (busy)
    );

    always #5 sensor_clk = ~sensor_clk;

    always @(posedge sensor_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One negedge step; pulses cfg_mask_wr when the frame offset matches
    task automatic nstep(input int t0, input int mwr_at, input logic [15:0] mwr_val);
        @(negedge sensor_clk);
        cfg_mask_wr = ((cyc - t0) == mwr_at);
        cfg_mask_in = mwr_val;
    endtask

    task automatic wait_start(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget && t < 0; i++) begin
            @(negedge sensor_clk);
            if (afe_conv_start) t = cyc;
        end
    endtask

    task automatic restart(input logic [15:0] per, input logic [7:0] st);
        enable = 1'b0;
        repeat (2) @(negedge sensor_clk);
        cfg_period = per;
        cfg_settle = st;
        enable     = 1'b1;
    endtask

    // One full frame: wait for the request, answer after dly cycles, optionally
    // hold the sweep busy for busy_len cycles from the done cycle, then capture
    // strobe timing, mask before/at the strobe and strobe level one/two cycles later.
    task automatic do_frame(input int dly, input int busy_len, input int mwr_at,
                            input logic [15:0] mwr_val,
                            output int t_start, output int t_strobe, output logic s_next,
                            output logic [15:0] m_pre, output logic [15:0] m_at,
                            output logic [1:0] tail);
        t_start = -1; t_strobe = -1; s_next = 1'b1;
        m_pre = 16'h0000; m_at = 16'h0000; tail = 2'b11;
        wait_start(3000, t_start);
        if (t_start < 0) return;
        for (int i = 0; i < dly; i++) begin
            nstep(t_start, mwr_at, mwr_val);
            if (i == 0) s_next = afe_conv_start;
        end
        afe_conv_done = 1'b1;
        if (busy_len > 0) sweep_busy_async = 1'b1;
        for (int i = 0; i < 100 && t_strobe < 0; i++) begin
            m_pre = channel_mask;
            nstep(t_start, mwr_at, mwr_val);
            afe_conv_done = 1'b0;
            if (i + 1 == busy_len) sweep_busy_async = 1'b0;
            if (sensor_valid_all) begin
                t_strobe = cyc;
                m_at     = channel_mask;
            end
        end
        afe_conv_done = 1'b0;
        sweep_busy_async = 1'b0;
        if (t_strobe < 0) return;
        nstep(t_start, mwr_at, mwr_val);
        tail[0] = sensor_valid_all;
        nstep(t_start, mwr_at, mwr_val);
        tail[1] = sensor_valid_all;
        cfg_mask_wr = 1'b0;
    endtask

    initial begin
        int ts, tst, ts2, tst2, t_to;
        logic sn;
        logic [15:0] mp, ma;
        logic [1:0] tl;
        logic seen;

        // Reset state
        repeat (3) @(negedge sensor_clk);
        check("rst_valid", sensor_valid_all, 1'b0);
        check("rst_start", afe_conv_start, 1'b0);
        check("rst_mask", channel_mask, 16'hFFFF);
        check("rst_fcount", frame_count, 16'd0);
        check("rst_errs", {overrun_err, timeout_err, busy}, 3'b000);
        rst_n = 1'b1;
        @(negedge sensor_clk);

        // 1. period 10, settle 3, done 2 cycles after start
        restart(16'd10, 8'd3);
        do_frame(2, 0, -1, 16'h0000, ts, tst, sn, mp, ma, tl);
        check("t1_latency", tst - ts, 6);
        check("t1_start_width", sn, 1'b0);
        check("t1_strobe_width", tl, 2'b01);
        check("t1_fcount1", frame_count, 16'd1);
        do_frame(2, 0, -1, 16'h0000, ts2, tst2, sn, mp, ma, tl);
        check("t1_period", ts2 - ts, 10);
        check("t1_latency2", tst2 - ts2, 6);
        check("t1_fcount2", frame_count, 16'd2);
        check("t1_no_overrun", overrun_err, 1'b0);

        // 2. sweep busy for 20 cycles around the publish point
        restart(16'd40, 8'd3);
        do_frame(2, 20, -1, 16'h0000, ts, tst, sn, mp, ma, tl);
        check("t2_latency", tst - ts, 25);
        check("t2_fcount", frame_count, 16'd3);
        wait_start(100, ts2);
        check("t2_next_start", ts2 - ts, 40);
        check("t2_no_overrun", overrun_err, 1'b0);

        // 3. period 4, done 8 cycles late: ticks dropped
        restart(16'd4, 8'd0);
        do_frame(8, 0, -1, 16'h0000, ts, tst, sn, mp, ma, tl);
        check("t3_latency", tst - ts, 9);
        check("t3_overrun_set", overrun_err, 1'b1);
        check("t3_fcount", frame_count, 16'd4);
        err_clr = 1'b1;
        @(negedge sensor_clk);
        err_clr = 1'b0;
        check("t3_overrun_clr", overrun_err, 1'b0);
        check("t3_restart", afe_conv_start, 1'b1);
        repeat (3) @(negedge sensor_clk);
        err_clr = 1'b1;   // same cycle as a dropped tick
        @(negedge sensor_clk);
        err_clr = 1'b0;
        check("t3_set_wins", overrun_err, 1'b1);
        repeat (4) @(negedge sensor_clk);
        afe_conv_done = 1'b1;
        @(negedge sensor_clk);
        afe_conv_done = 1'b0;
        check("t3_strobe_s0", sensor_valid_all, 1'b1);
        check("t3_fcount2", frame_count, 16'd5);

        // 4. AFE never answers
        enable = 1'b0;
        err_clr = 1'b1;
        @(negedge sensor_clk);
        err_clr = 1'b0;
        check("t4_errs_clr", {overrun_err, timeout_err}, 2'b00);
        restart(16'd2000, 8'd3);
        wait_start(2100, ts);
        t_to = -1;
        seen = 1'b0;
        for (int i = 0; i < 1100 && t_to < 0; i++) begin
            @(negedge sensor_clk);
            if (sensor_valid_all) seen = 1'b1;
            if (timeout_err) t_to = cyc;
        end
        check("t4_timeout_at", t_to - ts, 1024);
        check("t4_no_strobe", seen, 1'b0);
        check("t4_idle_busy", busy, 1'b0);
        check("t4_no_overrun", overrun_err, 1'b0);
        do_frame(2, 0, -1, 16'h0000, ts2, tst2, sn, mp, ma, tl);
        check("t4_next_frame", ts2 - ts, 2000);
        check("t4_fcount", frame_count, 16'd6);

        // 5. staged mask updates
        restart(16'd10, 8'd3);
        do_frame(2, 0, 1, 16'h00FF, ts, tst, sn, mp, ma, tl);
        check("t5a_mask_pre", mp, 16'hFFFF);
        check("t5a_mask_at", ma, 16'h00FF);
        do_frame(2, 0, 6, 16'h0F0F, ts, tst, sn, mp, ma, tl);
        check("t5b_mask_at", ma, 16'h00FF);
        do_frame(2, 0, 5, 16'h5555, ts, tst, sn, mp, ma, tl);
        check("t5c_mask_pre", mp, 16'h00FF);
        check("t5c_mask_at", ma, 16'h0F0F);
        do_frame(2, 0, -1, 16'h0000, ts, tst, sn, mp, ma, tl);
        check("t5d_mask_at", ma, 16'h5555);
        check("t5_fcount", frame_count, 16'd10);

        // 6a. enable dropped in SETTLE
        restart(16'd10, 8'd3);
        wait_start(100, ts);
        repeat (2) @(negedge sensor_clk);
        afe_conv_done = 1'b1;
        @(negedge sensor_clk);
        afe_conv_done = 1'b0;
        @(negedge sensor_clk);
        enable = 1'b0;
        @(negedge sensor_clk);
        check("t6a_busy", busy, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge sensor_clk);
            if (sensor_valid_all || afe_conv_start) seen = 1'b1;
        end
        check("t6a_quiet", seen, 1'b0);
        check("t6a_mask_kept", channel_mask, 16'h5555);
        check("t6a_fcount_kept", frame_count, 16'd10);

        // 6b. reset pulsed in CONVERT
        enable = 1'b1;
        wait_start(100, ts);
        @(negedge sensor_clk);
        rst_n = 1'b0;
        @(negedge sensor_clk);
        check("t6b_mask", channel_mask, 16'hFFFF);
        check("t6b_fcount", frame_count, 16'd0);
        check("t6b_flags", {sensor_valid_all, afe_conv_start, busy, overrun_err, timeout_err}, 5'b00000);
        enable = 1'b0;
        rst_n  = 1'b1;
        repeat (3) @(negedge sensor_clk);
        check("t6b_after", {sensor_valid_all, busy}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
